// File: rtl/spi_cmd_ctl_if.sv
// SPI-byte / system-bus signal bundle for spi_cmd_ctl.
// master: the command controller. slave: the SPI engine and bus side around it.
interface spi_cmd_ctl_if #(
    parameter int unsigned ADDR_WIDTH = 17
);
    logic                  spi_cs_ni;
    logic                  rx_valid_i;
    logic [7:0]            rx_byte_i;
    logic [7:0]            tx_byte_o;
    logic [ADDR_WIDTH-1:0] addr_o;
    logic [7:0]            wr_data_o;
    logic                  we_o;
    logic                  pending_o;
    logic                  done_i;
    logic [7:0]            rd_data_i;

    modport master (
        input  spi_cs_ni, rx_valid_i, rx_byte_i, done_i, rd_data_i,
        output tx_byte_o, addr_o, wr_data_o, we_o, pending_o
    );

    modport slave (
        output spi_cs_ni, rx_valid_i, rx_byte_i, done_i, rd_data_i,
        input  tx_byte_o, addr_o, wr_data_o, we_o, pending_o
    );
endinterface

// File: rtl/spi_cmd_ctl.sv
// SPI command sequencer: decodes READ/WRITE byte commands with a 17-bit address
// and runs one pending/done bus transaction per SPI frame.
// Optional feature macro: SPI_CMD_AUTOINC_EN enables READ_NEXT/WRITE_NEXT and
// the post-transaction address increment.
module spi_cmd_ctl #(
    parameter int unsigned ADDR_WIDTH = 17
) (
    input  logic          clk_sys_i,
    input  logic          reset_ni,
    spi_cmd_ctl_if.master bus
);

    typedef enum logic [2:0] {
        StCmd,
        StAddrHi,
        StAddrLo,
        StData,
        StBusy,
        StDoneWait
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            wr_data_q, wr_data_d;
    logic [7:0]            tx_byte_q, tx_byte_d;
    logic                  we_q, we_d;

    // State and datapath registers.
    always_ff @(posedge clk_sys_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= StCmd;
            addr_q    <= '0;
            wr_data_q <= 8'h00;
            tx_byte_q <= 8'h00;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            tx_byte_q <= tx_byte_d;
            we_q      <= we_d;
        end
    end

    // Next-state decode; chip-select abort takes priority over a same-cycle byte.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        tx_byte_d = tx_byte_q;
        we_d      = we_q;

        unique case (state_q)
            StCmd: begin
                if (!bus.spi_cs_ni && bus.rx_valid_i) begin
                    case (bus.rx_byte_i[7:6])
                        2'b00: begin
                            we_d                 = 1'b0;
                            addr_d[ADDR_WIDTH-1] = bus.rx_byte_i[0];
                            state_d              = StAddrHi;
                        end
                        2'b01: begin
                            we_d                 = 1'b1;
                            addr_d[ADDR_WIDTH-1] = bus.rx_byte_i[0];
                            state_d              = StAddrHi;
                        end
`ifdef SPI_CMD_AUTOINC_EN
                        2'b10: begin
                            we_d    = 1'b0;
                            state_d = StBusy;
                        end
                        default: begin
                            we_d    = 1'b1;
                            state_d = StData;
                        end
`else
                        // _NEXT opcodes are illegal: swallow the rest of the frame.
                        default: state_d = StDoneWait;
`endif
                    endcase
                end
            end
            StAddrHi: begin
                if (bus.spi_cs_ni) begin
                    state_d = StCmd;
                end else if (bus.rx_valid_i) begin
                    addr_d[15:8] = bus.rx_byte_i;
                    state_d      = StAddrLo;
                end
            end
            StAddrLo: begin
                if (bus.spi_cs_ni) begin
                    state_d = StCmd;
                end else if (bus.rx_valid_i) begin
                    addr_d[7:0] = bus.rx_byte_i;
                    state_d     = we_q ? StData : StBusy;
                end
            end
            StData: begin
                if (bus.spi_cs_ni) begin
                    state_d = StCmd;
                end else if (bus.rx_valid_i) begin
                    wr_data_d = bus.rx_byte_i;
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                // Chip select is deliberately ignored here: the bus request must finish.
                if (bus.done_i) begin
                    if (!we_q) begin
                        tx_byte_d = bus.rd_data_i;
                    end
`ifdef SPI_CMD_AUTOINC_EN
                    addr_d = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
`endif
                    state_d = StDoneWait;
                end
            end
            StDoneWait: begin
                if (bus.spi_cs_ni) begin
                    state_d = StCmd;
                end
            end
            default: state_d = StCmd;
        endcase
    end

    // Outputs come straight from registers so they stay stable during a request.
    assign bus.pending_o = (state_q == StBusy);
    assign bus.addr_o    = addr_q;
    assign bus.wr_data_o = wr_data_q;
    assign bus.tx_byte_o = tx_byte_q;
    assign bus.we_o      = we_q;

endmodule

// File: tb/tb_spi_cmd_ctl.sv
// Self-checking bench for spi_cmd_ctl: directed scenarios with literal
// expectations, then randomized frames against a byte-count reference model.
module tb_spi_cmd_ctl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_cmd_ctl_if #(.ADDR_WIDTH(17)) bus ();

    spi_cmd_ctl #(.ADDR_WIDTH(17)) dut (
        .clk_sys_i (clk),
        .reset_ni  (rst_n),
        .bus       (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks how many bytes of the current command have arrived and what the
    // outputs must be, purely from the command-format rules.
    logic [16:0] m_addr;
    logic [7:0]  m_tx, m_wr, m_cmd;
    logic        m_we, m_pend, m_lock;
    int          m_cnt;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_addr = '0; m_tx = 8'h00; m_wr = 8'h00; m_cmd = 8'h00;
                m_we = 1'b0; m_pend = 1'b0; m_lock = 1'b0; m_cnt = 0;
            end else if (m_pend) begin
                if (bus.done_i) begin
                    m_pend = 1'b0;
                    if (!m_we) m_tx = bus.rd_data_i;
`ifdef SPI_CMD_AUTOINC_EN
                    m_addr = m_addr + 17'd1;
`endif
                    m_lock = 1'b1;
                end
            end else if (m_lock) begin
                if (bus.spi_cs_ni) m_lock = 1'b0;
            end else if (bus.spi_cs_ni) begin
                m_cnt = 0;
            end else if (bus.rx_valid_i) begin
                int need;
                if (m_cnt == 0) m_cmd = bus.rx_byte_i;
                m_cnt++;
                if (m_cmd[7]) begin
`ifdef SPI_CMD_AUTOINC_EN
                    if (m_cmd[6] && m_cnt == 2) m_wr = bus.rx_byte_i;
                    need = m_cmd[6] ? 2 : 1;
                    if (m_cnt == need) begin
                        m_pend = 1'b1; m_we = m_cmd[6]; m_cnt = 0;
                    end
`else
                    m_lock = 1'b1;
                    m_cnt  = 0;
`endif
                end else begin
                    case (m_cnt)
                        1: m_addr[16]   = bus.rx_byte_i[0];
                        2: m_addr[15:8] = bus.rx_byte_i;
                        3: m_addr[7:0]  = bus.rx_byte_i;
                        4: m_wr         = bus.rx_byte_i;
                        default: ;
                    endcase
                    need = m_cmd[6] ? 4 : 3;
                    if (m_cnt == need) begin
                        m_pend = 1'b1; m_we = m_cmd[6]; m_cnt = 0;
                    end
                end
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("pending", 32'(bus.pending_o), 32'(m_pend));
                chk("addr", 32'(bus.addr_o), 32'(m_addr));
                chk("tx_byte", 32'(bus.tx_byte_o), 32'(m_tx));
                chk("wr_data", 32'(bus.wr_data_o), 32'(m_wr));
                if (m_pend) chk("we", 32'(bus.we_o), 32'(m_we));
            end
        end
    end

    // ---------------- bus responder ----------------
    int         resp_lat    = 0;
    logic [7:0] resp_rd     = 8'h00;
    bit         spurious_en = 1'b0;
    bit         busy_seen   = 1'b0;
    int         wait_cnt    = 0;

    initial begin
        bus.done_i    = 1'b0;
        bus.rd_data_i = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            bus.done_i    = 1'b0;
            bus.rd_data_i = 8'($urandom);
            if (!rst_n || !bus.pending_o) begin
                busy_seen = 1'b0;
                if (spurious_en && rst_n && $urandom_range(0, 7) == 0) bus.done_i = 1'b1;
            end else begin
                if (!busy_seen) begin
                    busy_seen = 1'b1;
                    wait_cnt  = resp_lat;
                end
                if (wait_cnt == 0) begin
                    bus.done_i    = 1'b1;
                    bus.rd_data_i = resp_rd;
                    busy_seen     = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        bus.rx_valid_i = 1'b1;
        bus.rx_byte_i  = b;
        tick();
        bus.rx_valid_i = 1'b0;
        bus.rx_byte_i  = 8'($urandom);
        repeat (gap) tick();
    endtask

    task automatic wait_free(input string tag);
        int n = 0;
        while (m_pend && n < 200) begin
            tick();
            n++;
        end
        if (m_pend) begin
            total++;
            bad++;
            $display("FAIL %s: request not finished after 200 cycles, got pending=1 want 0", tag);
        end
    endtask

    task automatic end_frame();
        bus.spi_cs_ni = 1'b1;
        tick();
        tick();
    endtask

    task automatic start_frame();
        bus.spi_cs_ni = 1'b0;
        tick();
    endtask

    task automatic count_pending(output int n);
        n = 0;
        while (bus.pending_o && n < 50) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        logic [7:0] q[$];
        logic [1:0] op;
        int abort_at;

        bus.spi_cs_ni  = 1'b1;
        bus.rx_valid_i = 1'b0;
        bus.rx_byte_i  = 8'h00;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("reset pending", 32'(bus.pending_o), 32'h0);
        chk("reset addr", 32'(bus.addr_o), 32'h0);
        chk("reset tx", 32'(bus.tx_byte_o), 32'h0);
        chk("reset wr_data", 32'(bus.wr_data_o), 32'h0);
        chk("reset we", 32'(bus.we_o), 32'h0);
        rst_n = 1'b1;
        tick();

        // Write 0xA5 to 0x12345, single-cycle bus latency.
        start_frame();
        resp_lat = 0;
        send(8'h41, 0); send(8'h23, 0); send(8'h45, 0); send(8'hA5, 0);
        chk("wr pending", 32'(bus.pending_o), 32'h1);
        chk("wr addr", 32'(bus.addr_o), 32'h12345);
        chk("wr we", 32'(bus.we_o), 32'h1);
        chk("wr data", 32'(bus.wr_data_o), 32'hA5);
        tick();
        chk("wr pending fall", 32'(bus.pending_o), 32'h0);
`ifdef SPI_CMD_AUTOINC_EN
        chk("wr addr after", 32'(bus.addr_o), 32'h12346);
`else
        chk("wr addr after", 32'(bus.addr_o), 32'h12345);
`endif
        end_frame();

        // Read from 0x1FFFF with done delayed 5 cycles.
        start_frame();
        resp_lat = 5;
        resp_rd  = 8'h3C;
        send(8'h01, 0); send(8'hFF, 0); send(8'hFF, 0);
        count_pending(n);
        chk("rd pending cycles", 32'(n), 32'd6);
        chk("rd tx", 32'(bus.tx_byte_o), 32'h3C);
`ifdef SPI_CMD_AUTOINC_EN
        chk("rd addr wrap", 32'(bus.addr_o), 32'h00000);
`else
        chk("rd addr hold", 32'(bus.addr_o), 32'h1FFFF);
`endif
        end_frame();

`ifdef SPI_CMD_AUTOINC_EN
        // READ_NEXT then WRITE_NEXT on the incremented address.
        start_frame();
        resp_lat = 0;
        send(8'h80, 0);
        chk("rdn pending", 32'(bus.pending_o), 32'h1);
        chk("rdn addr", 32'(bus.addr_o), 32'h00000);
        chk("rdn we", 32'(bus.we_o), 32'h0);
        wait_free("rdn");
        end_frame();
        start_frame();
        send(8'hC0, 0); send(8'h77, 0);
        chk("wrn pending", 32'(bus.pending_o), 32'h1);
        chk("wrn addr", 32'(bus.addr_o), 32'h00001);
        chk("wrn we", 32'(bus.we_o), 32'h1);
        chk("wrn data", 32'(bus.wr_data_o), 32'h77);
        wait_free("wrn");
        end_frame();
`else
        // Illegal _NEXT opcode: nothing happens, next frame works.
        start_frame();
        send(8'h80, 0);
        chk("illegal pending", 32'(bus.pending_o), 32'h0);
        repeat (3) tick();
        chk("illegal pending later", 32'(bus.pending_o), 32'h0);
        chk("illegal addr", 32'(bus.addr_o), 32'h1FFFF);
        end_frame();
        start_frame();
        resp_lat = 1;
        resp_rd  = 8'h5E;
        send(8'h00, 0); send(8'h12, 0); send(8'h34, 0);
        chk("post-illegal pending", 32'(bus.pending_o), 32'h1);
        chk("post-illegal addr", 32'(bus.addr_o), 32'h01234);
        wait_free("post-illegal");
        chk("post-illegal tx", 32'(bus.tx_byte_o), 32'h5E);
        end_frame();
`endif

        // Abort mid-command, then a full write.
        start_frame();
        send(8'h40, 0); send(8'h10, 0);
        bus.spi_cs_ni = 1'b1;
        tick();
        chk("abort pending", 32'(bus.pending_o), 32'h0);
        tick();
        start_frame();
        resp_lat = 2;
        send(8'h41, 0); send(8'h00, 0); send(8'h07, 0); send(8'h5A, 0);
        chk("post-abort pending", 32'(bus.pending_o), 32'h1);
        chk("post-abort addr", 32'(bus.addr_o), 32'h10007);
        chk("post-abort data", 32'(bus.wr_data_o), 32'h5A);
        wait_free("post-abort");
        end_frame();

        // Chip select rises while busy: request still held until done.
        start_frame();
        resp_lat = 3;
        resp_rd  = 8'h99;
        send(8'h00, 0); send(8'hAB, 0); send(8'hCD, 0);
        bus.spi_cs_ni = 1'b1;
        count_pending(n);
        chk("cs-busy pending cycles", 32'(n), 32'd4);
        chk("cs-busy tx", 32'(bus.tx_byte_o), 32'h99);
        tick();

        // Second command in one frame is ignored.
        start_frame();
        resp_lat = 0;
        send(8'h41, 0); send(8'h00, 0); send(8'h00, 0); send(8'h11, 0);
        wait_free("first cmd");
        send(8'h41, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        chk("second cmd pending", 32'(bus.pending_o), 32'h0);
        chk("second cmd data", 32'(bus.wr_data_o), 32'h11);
        end_frame();

        // Reset in the middle of a request drops pending immediately.
        start_frame();
        resp_lat = 10;
        send(8'h00, 0); send(8'h00, 0); send(8'h05, 0);
        chk("pre-reset pending", 32'(bus.pending_o), 32'h1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset pending", 32'(bus.pending_o), 32'h0);
        chk("async reset addr", 32'(bus.addr_o), 32'h0);
        bus.spi_cs_ni = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized frames.
        spurious_en = 1'b1;
        for (int f = 0; f < 150; f++) begin
            start_frame();
            resp_lat = $urandom_range(0, 4);
            resp_rd  = 8'($urandom);
            op       = 2'($urandom_range(0, 3));
            q.delete();
            q.push_back({op, 5'($urandom), 1'($urandom)});
            if (!op[1]) begin
                q.push_back(8'($urandom));
                q.push_back(8'($urandom));
            end
            if (op[0]) q.push_back(8'($urandom));
            repeat ($urandom_range(0, 2)) q.push_back(8'($urandom));
            abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, q.size() - 1) : q.size();
            for (int i = 0; i < q.size(); i++) begin
                if (i == abort_at) break;
                send(q[i], $urandom_range(0, 2));
            end
            if ($urandom_range(0, 3) == 0) begin
                bus.rx_valid_i = 1'b1;
                bus.rx_byte_i  = 8'($urandom);
            end
            bus.spi_cs_ni = 1'b1;
            tick();
            bus.rx_valid_i = 1'b0;
            wait_free("random frame");
            repeat ($urandom_range(1, 2)) tick();
        end

        spurious_en = 1'b0;
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_cmd_ctl.md
# spi_cmd_ctl

Command sequencer between the SPI byte engine and the system bus. It consumes bytes from the SPI target (already in the `clk_sys` domain), decodes read and write commands carrying a 17-bit address, and runs one bus transaction per command through a pending/done handshake. Read data is returned through the SPI transmit byte.

## Interface
- `ADDR_WIDTH`, 17: bus address width; the command byte carries the MSB and two further bytes carry bits [15:0].
- `clk_sys_i` in 1: system clock; all logic is on its rising edge.
- `reset_ni` in 1: asynchronous, active-low reset.
- `spi_cs_ni` in 1: SPI chip select, already synchronized to `clk_sys_i`; high means the frame is idle or aborted.
- `rx_valid_i` in 1: one-cycle strobe; `rx_byte_i` holds a completed byte.
- `rx_byte_i` in 8: received byte.
- `tx_byte_o` out 8: byte shifted out on the next SPI byte; holds the most recent read data.
- `addr_o` out ADDR_WIDTH: bus address.
- `wr_data_o` out 8: write data.
- `we_o` out 1: 1 for write, 0 for read; valid while `pending_o` is high.
- `pending_o` out 1: bus request.
- `done_i` in 1: one-cycle bus completion strobe.
- `rd_data_i` in 8: read data, sampled in the cycle `done_i` is high.

## Operation
- Command byte format: [7:6] opcode: 00 READ, 01 WRITE, 10 READ_NEXT, 11 WRITE_NEXT. [5:1] reserved and ignored. [0] address bit 16.
- READ: cmd, addr_hi, addr_lo. WRITE: cmd, addr_hi, addr_lo, data.
- READ_NEXT: cmd alone, using the stored address. WRITE_NEXT: cmd, data. Bit 0 is ignored for the `_NEXT` opcodes.
- States:
  - CMD: wait for a byte. READ and WRITE go to ADDR_HI. READ_NEXT goes to BUSY. WRITE_NEXT goes to DATA.
  - ADDR_HI: load addr[15:8], then go to ADDR_LO.
  - ADDR_LO: load addr[7:0]. READ goes to BUSY; WRITE goes to DATA.
  - DATA: load `wr_data_o`, then go to BUSY.
  - BUSY: `pending_o` is high. On `done_i`, go to DONE_WAIT.
  - DONE_WAIT: wait for `spi_cs_ni` high, then go to CMD. Only one command is accepted per frame; bytes arriving in this state are ignored.
- Address bit 16 loads from cmd[0] in the same cycle the command byte is accepted, for READ and WRITE only.
- After every completed transaction the address increments by 1 modulo 2^ADDR_WIDTH: 0x1FFFF wraps to 0x00000. The next `_NEXT` command uses the incremented value.
- Reads: `tx_byte_o` <= `rd_data_i` on `done_i`. Writes leave `tx_byte_o` unchanged.
- `spi_cs_ni` high in CMD, ADDR_HI, ADDR_LO or DATA aborts to CMD. The address keeps any bytes already loaded, and no transaction is issued.
- `spi_cs_ni` high in BUSY does not drop `pending_o`. The transaction completes, including the increment and read capture, and the controller then returns to CMD.
- `rx_valid_i` in BUSY is ignored.
- `done_i` while `pending_o` is low is ignored.

## Timing
- Reset values: state CMD, `addr_o` 0, `wr_data_o` 0x00, `tx_byte_o` 0x00, `we_o` 0, `pending_o` 0.
- `pending_o` rises on the clock edge that samples the final `rx_valid_i` of a command. It is high one cycle after that strobe.
- `addr_o`, `we_o` and `wr_data_o` are stable from the rise of `pending_o` until it falls.
- `pending_o` falls on the edge that samples `done_i`. The address increment and `tx_byte_o` update happen on that same edge.
- Minimum bus latency is 1 cycle, with `done_i` high in the first cycle `pending_o` is high.
- `rx_valid_i` and a rising `spi_cs_ni` in the same cycle: the abort wins and the byte is dropped.
- Asserting `reset_ni` mid-transaction clears `pending_o` immediately (asynchronously). The bus owner must tolerate an abandoned request.

## Configuration
- `SPI_CMD_AUTOINC_EN` defined: READ_NEXT and WRITE_NEXT are decoded as described, and the address increments after each transaction.
- `SPI_CMD_AUTOINC_EN` undefined:
  - Opcodes 10 and 11 are illegal. The controller goes directly to DONE_WAIT with no bus activity.
  - No address increment; `addr_o` holds the last loaded value.

## Test plan
- Reset, then write 0x41,0x23,0x45,0xA5 → one pending cycle with `addr_o`=0x12345, `we_o`=1, `wr_data_o`=0xA5. Afterwards `addr_o`=0x12346.
- Read 0x01,0xFF,0xFF with `rd_data_i`=0x3C and `done_i` delayed 5 cycles → `pending_o` high for exactly 6 cycles. Then `tx_byte_o`=0x3C and `addr_o` wraps to 0x00000.
- With `SPI_CMD_AUTOINC_EN` defined, after the read above send READ_NEXT 0x80 → `pending_o` rises 1 cycle after the strobe with `addr_o`=0x00000. Then send WRITE_NEXT 0xC0,0x77 → write of 0x77 at 0x00001.
- Write 0x40,0x10 followed by `spi_cs_ni` high → no pending, state returns to CMD. The next full write executes normally.
- `spi_cs_ni` high while in BUSY, `done_i` 3 cycles later → `pending_o` held until `done_i`, then CMD. A second command in the same frame, sent before `spi_cs_ni` toggles, is ignored.
- With `SPI_CMD_AUTOINC_EN` undefined, send 0x80 → no `pending_o` and address unchanged. The following frame's READ executes normally.
